if_stage: RTL and testbench

Instruction-fetch stage between the PC register and decode. It issues word fetches to instruction memory over a req/ack handshake at the address the PC register holds, and drives `pc_adv` as the PC register's write enable. Fetched words are captured into the IF/ID pipeline register, with a one-entry skid buffer for decode stalls. Branch or jump redirects (`flush_i`) discard in-flight or buffered instructions without breaking the memory handshake.

---
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives word fetches over a req/ack handshake, advances the PC,
// and fills the IF/ID register through a one-entry skid buffer, discarding work on redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [31:0] npc_i,
    output logic        pc_adv,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        ld_mem;
    logic        ld_skid;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        pc_adv       = 1'b0;
        imem_req     = 1'b0;
        ld_mem       = 1'b0;
        ld_skid      = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (flush_i) begin
                    pc_adv = 1'b1;
                    addr_d = npc_i;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_adv = 1'b1;
                    addr_d = npc_i;
                    if (!flush_i) begin
                        if (!valid_q || !stall_i) begin
                            ld_mem = 1'b1;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = addr_q;
                            state_d      = HOLD;
                        end
                    end
                end else if (flush_i) begin
                    // Address must stay stable until ack, so only the PC takes the target.
                    pc_adv  = 1'b1;
                    state_d = DROP;
                end
            end
            DROP: begin
                imem_req = 1'b1;
                if (flush_i) begin
                    pc_adv = 1'b1;
                end
                if (imem_ack) begin
                    // A redirect landing on the same edge moves the PC again; follow it.
                    addr_d  = flush_i ? npc_i : pc_i;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pc_adv  = 1'b1;
                    addr_d  = npc_i;
                    state_d = REQ;
                end else if (!stall_i) begin
                    ld_skid = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID register: flush beats any load, a stalled valid entry holds, otherwise bubble.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ld_mem) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ipc_d   = addr_q;
        end else if (ld_skid) begin
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            ipc_d   = skid_pc_q;
        end else if (!(stall_i && valid_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= RESET_PC;
            valid_q      <= 1'b0;
            instr_q      <= 32'd0;
            ipc_q        <= 32'd0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            ipc_q        <= ipc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_addr   = addr_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_pc4   = ipc_q + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural PC register and a memory that returns
// 0x5A5A0000 | address for every fetch.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_r;
    logic [31:0] npc;
    logic        pc_adv;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] tgt;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;

    int n_cmp = 0;
    int n_err = 0;
    int adv_cnt = 0;
    int adv_snap;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_r),
        .npc_i      (npc),
        .pc_adv     (pc_adv),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign npc        = flush_i ? tgt : pc_r + 32'd4;
    assign imem_rdata = 32'h5A5A_0000 | imem_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) pc_r <= RST_PC;
        else if (pc_adv) pc_r <= npc;
    end

    always @(posedge clk) begin
        if (rst && pc_adv) adv_cnt <= adv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req),    32'd0);
        chk({tag, "_addr"},  imem_addr,        RST_PC);
        chk({tag, "_adv"},   32'(pc_adv),      32'd0);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_instr"}, if_id_instr,      32'd0);
        chk({tag, "_pc"},    if_id_pc,         32'd0);
        chk({tag, "_pc4"},   if_id_pc4,        32'd4);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall_i = 1'b0; flush_i = 1'b0; tgt = 32'd0;
        #1 rst = 1'b0;
        #2 chk_reset("rst");
        cyc();
        cyc();

        // Zero-wait memory
        rst = 1'b1; imem_ack = 1'b1; #1;
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_adv", 32'(pc_adv), 32'd0);
        cyc(); #1;
        chk("zw0_req",   32'(imem_req), 32'd1);
        chk("zw0_addr",  imem_addr, 32'h3000);
        chk("zw0_adv",   32'(pc_adv), 32'd1);
        chk("zw0_valid", 32'(if_id_valid), 32'd0);
        cyc(); #1;
        chk("zw1_addr",  imem_addr, 32'h3004);
        chk("zw1_valid", 32'(if_id_valid), 32'd1);
        chk("zw1_pc",    if_id_pc, 32'h3000);
        chk("zw1_pc4",   if_id_pc4, 32'h3004);
        chk("zw1_instr", if_id_instr, 32'h5A5A_3000);
        cyc();
        imem_ack = 1'b0; #1;
        chk("zw2_addr", imem_addr, 32'h3008);
        chk("zw2_pc",   if_id_pc, 32'h3004);
        chk("zw2_inv",  imem_addr, pc_r);
        chk("ws0_adv",  32'(pc_adv), 32'd0);
        adv_snap = adv_cnt;

        // Two wait states
        cyc(); #1;
        chk("ws1_req",   32'(imem_req), 32'd1);
        chk("ws1_addr",  imem_addr, 32'h3008);
        chk("ws1_valid", 32'(if_id_valid), 32'd0);
        chk("ws1_adv",   32'(pc_adv), 32'd0);
        cyc();
        imem_ack = 1'b1; #1;
        chk("ws2_addr", imem_addr, 32'h3008);
        chk("ws2_adv",  32'(pc_adv), 32'd1);
        cyc();
        stall_i = 1'b1; #1;
        chk("ws_pulses", 32'(adv_cnt - adv_snap), 32'd1);
        chk("ws_valid",  32'(if_id_valid), 32'd1);
        chk("ws_instr",  if_id_instr, 32'h5A5A_3008);
        chk("ws_pc",     if_id_pc, 32'h3008);
        chk("ws_addr",   imem_addr, 32'h300C);

        // Stall with ack -> skid
        chk("sk0_adv", 32'(pc_adv), 32'd1);
        cyc(); #1;
        chk("sk1_req",  32'(imem_req), 32'd0);
        chk("sk1_adv",  32'(pc_adv), 32'd0);
        chk("sk1_pc",   if_id_pc, 32'h3008);
        chk("sk1_addr", imem_addr, 32'h3010);
        cyc(); #1;
        chk("sk2_req",   32'(imem_req), 32'd0);
        chk("sk2_valid", 32'(if_id_valid), 32'd1);
        chk("sk2_pc",    if_id_pc, 32'h3008);
        cyc();
        stall_i = 1'b0; #1;
        chk("sk3_adv", 32'(pc_adv), 32'd0);
        chk("sk3_req", 32'(imem_req), 32'd0);
        cyc(); #1;
        chk("sk4_valid", 32'(if_id_valid), 32'd1);
        chk("sk4_pc",    if_id_pc, 32'h300C);
        chk("sk4_instr", if_id_instr, 32'h5A5A_300C);
        chk("sk4_addr",  imem_addr, 32'h3010);
        chk("sk4_adv",   32'(pc_adv), 32'd1);
        cyc();
        imem_ack = 1'b0; #1;
        chk("sk5_pc",   if_id_pc, 32'h3010);
        chk("sk5_addr", imem_addr, 32'h3014);

        // Flush in REQ without ack
        flush_i = 1'b1; tgt = 32'h4000; #1;
        chk("fr0_adv",  32'(pc_adv), 32'd1);
        chk("fr0_addr", imem_addr, 32'h3014);
        cyc();
        flush_i = 1'b0; #1;
        chk("fr1_req",   32'(imem_req), 32'd1);
        chk("fr1_addr",  imem_addr, 32'h3014);
        chk("fr1_valid", 32'(if_id_valid), 32'd0);
        chk("fr1_adv",   32'(pc_adv), 32'd0);
        chk("fr1_pcreg", pc_r, 32'h4000);
        cyc();
        imem_ack = 1'b1; #1;
        chk("fr2_addr",  imem_addr, 32'h3014);
        chk("fr2_adv",   32'(pc_adv), 32'd0);
        chk("fr2_valid", 32'(if_id_valid), 32'd0);
        cyc(); #1;
        chk("fr3_addr",  imem_addr, 32'h4000);
        chk("fr3_valid", 32'(if_id_valid), 32'd0);
        chk("fr3_adv",   32'(pc_adv), 32'd1);
        cyc(); #1;
        chk("fr4_valid", 32'(if_id_valid), 32'd1);
        chk("fr4_pc",    if_id_pc, 32'h4000);
        chk("fr4_instr", if_id_instr, 32'h5A5A_4000);
        chk("fr4_addr",  imem_addr, 32'h4004);

        // Flush together with ack
        flush_i = 1'b1; tgt = 32'h5000; #1;
        chk("fa0_adv", 32'(pc_adv), 32'd1);
        cyc();
        flush_i = 1'b0; #1;
        chk("fa1_addr",  imem_addr, 32'h5000);
        chk("fa1_valid", 32'(if_id_valid), 32'd0);
        cyc();
        stall_i = 1'b1; #1;
        chk("fa2_pc",   if_id_pc, 32'h5000);
        chk("fa2_addr", imem_addr, 32'h5004);

        // Flush while parked in HOLD
        cyc();
        flush_i = 1'b1; tgt = 32'h6000; #1;
        chk("fh0_req",  32'(imem_req), 32'd0);
        chk("fh0_adv",  32'(pc_adv), 32'd1);
        chk("fh0_addr", imem_addr, 32'h5008);
        cyc();
        flush_i = 1'b0; stall_i = 1'b0; #1;
        chk("fh1_valid", 32'(if_id_valid), 32'd0);
        chk("fh1_addr",  imem_addr, 32'h6000);
        chk("fh1_req",   32'(imem_req), 32'd1);
        chk("fh1_inv",   imem_addr, pc_r);
        cyc();
        imem_ack = 1'b0; stall_i = 1'b1; #1;
        chk("fh2_pc",    if_id_pc, 32'h6000);
        chk("fh2_valid", 32'(if_id_valid), 32'd1);

        // Asynchronous reset during an outstanding request
        cyc(); #1;
        chk("ar0_req",   32'(imem_req), 32'd1);
        chk("ar0_addr",  imem_addr, 32'h6004);
        chk("ar0_valid", 32'(if_id_valid), 32'd1);
        rst = 1'b0; #1;
        chk_reset("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
